// File: rtl/hdmi_axi_line_fetch.sv
// Per-scanline AXI read-burst request generator in the pixel clock domain.
// Optional sticky overrun flag: define HDMI_AXI_LINE_FETCH_OVERRUN_EN.
module hdmi_axi_line_fetch #(
    parameter logic [11:0] X_SIZE    = 12'd256,
    parameter logic [11:0] Y_SIZE    = 12'd256,
    parameter logic [8:0]  BURST_LEN = 9'd64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        prefetch_line,
    input  logic [1:0]  pixelena_edge,
    input  logic        busy,
    output logic        kick,
    output logic [31:0] read_addr,
    output logic [8:0]  read_num
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] KICK      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [11:0] BURSTS     = X_SIZE / {3'b000, BURST_LEN};
    localparam logic [11:0] LAST_BURST = BURSTS - 12'd1;

    // Handshake: kick is a one-cycle strobe with read_addr/read_num valid in
    // that cycle; the master acknowledges by raising busy and completes the
    // burst by dropping it. The next kick waits for busy to fall.
    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [11:0] burst_idx;
    logic [11:0] burst_nx;
    logic [11:0] fetch_line;
    logic [11:0] disp_line;
    logic        pending;
    logic        resync_pend;
    logic [31:0] addr_nx;
    logic        disp_wrap;
    logic        fetch_done;
    logic        idle_quiet;

    assign kick     = (state == KICK);
    assign read_num = BURST_LEN;

    assign disp_wrap  = (pixelena_edge == 2'b10) && (disp_line == Y_SIZE - 12'd1);
    assign fetch_done = (state == WAIT_DONE) && !busy && (burst_idx == LAST_BURST);
    // Only a truly quiet FSM may have its line counter forced immediately.
    assign idle_quiet = (state == IDLE) && !pending && !prefetch_line;

    assign addr_nx = BASE_ADDR +
        (({20'd0, fetch_line} * {20'd0, X_SIZE} +
          {20'd0, burst_nx} * {23'd0, BURST_LEN}) << 2);

    always_comb begin
        state_nx = state;
        burst_nx = burst_idx;
        case (state)
            IDLE: begin
                if (prefetch_line || pending) begin
                    state_nx = KICK;
                    burst_nx = 12'd0;
                end
            end
            KICK:      state_nx = WAIT_BUSY;
            WAIT_BUSY: if (busy) state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (!busy) begin
                    if (burst_idx != LAST_BURST) begin
                        burst_nx = burst_idx + 12'd1;
                        state_nx = KICK;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_idx <= 12'd0;
            read_addr <= BASE_ADDR;
        end else begin
            state     <= state_nx;
            burst_idx <= burst_nx;
            if (state_nx == KICK) read_addr <= addr_nx;
        end
    end

    // A pulse in the IDLE cycle that consumes pending is itself queued.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (state == IDLE) begin
            pending <= pending & prefetch_line;
        end else if (prefetch_line) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            disp_line <= 12'd0;
        end else if (pixelena_edge == 2'b10) begin
            disp_line <= disp_wrap ? 12'd0 : disp_line + 12'd1;
        end
    end

    // Frame resync: a display wrap during a fetch is deferred to its end.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            fetch_line  <= 12'd0;
            resync_pend <= 1'b0;
        end else if (fetch_done) begin
            resync_pend <= 1'b0;
            if (resync_pend || disp_wrap || fetch_line == Y_SIZE - 12'd1)
                fetch_line <= 12'd0;
            else
                fetch_line <= fetch_line + 12'd1;
        end else if (disp_wrap) begin
            if (idle_quiet) fetch_line <= 12'd0;
            else            resync_pend <= 1'b1;
        end
    end

`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if ((prefetch_line && pending && state != IDLE) ||
                     (pixelena_edge == 2'b01 && state != IDLE &&
                      fetch_line == disp_line)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_axi_line_fetch.sv
// Scoreboard bench for hdmi_axi_line_fetch: a line/frame model queues the
// expected burst addresses, a monitor pops and checks each kick.
module tb_hdmi_axi_line_fetch;

    logic        clk_vga = 1'b0;
    logic        rst = 1'b0;
    logic        prefetch_line = 1'b0;
    logic [1:0]  pixelena_edge = 2'b00;
    logic        busy = 1'b0;
    logic        kick;
    logic [31:0] read_addr;
    logic [8:0]  read_num;
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
    logic        overrun;
    logic        exp_overrun = 1'b0;
`endif

    hdmi_axi_line_fetch dut (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .prefetch_line (prefetch_line),
        .pixelena_edge (pixelena_edge),
        .busy          (busy),
        .kick          (kick),
        .read_addr     (read_addr),
        .read_num      (read_num)
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
        ,
        .overrun       (overrun)
`endif
    );

    // clock / reset
    always #5 clk_vga = ~clk_vga;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int kick_count = 0;
    int last_kick_cycle = -1;
    int release_cycle = 0;
    bit hold_long = 1'b0;
    bit resp_active = 1'b0;

    // reference model state: frame geometry 256 x 256, 4 bursts of 64 pixels
    logic [31:0] exp_q[$];
    int m_line = 0;
    int m_disp = 0;

    always @(posedge clk_vga) cycle <= cycle + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk_vga) begin
        if (rst && kick) begin
            kick_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_kick", read_addr, 32'hFFFF_FFFF);
            end else begin
                check("read_addr", read_addr, exp_q.pop_front());
            end
            check("read_num", {23'd0, read_num}, 32'd64);
            check("kick_while_busy", {31'd0, busy}, 32'd0);
            check("addr_bound", {31'd0, (read_addr + 32'd252) <= 32'h3FFFC}, 32'd1);
            if (last_kick_cycle >= 0)
                check("kick_spacing_ge3", {31'd0, (cycle - last_kick_cycle) >= 3}, 32'd1);
            last_kick_cycle = cycle;
        end
    end

    // read-master responder: busy 1 cycle after kick, 9..24 cycles long
    initial begin
        int n;
        forever begin
            @(negedge clk_vga);
            if (rst && kick) begin
                resp_active = 1'b1;
                @(posedge clk_vga); #1 busy = 1'b1;
                n = hold_long ? 1000 : int'($urandom_range(9, 24));
                repeat (n) @(posedge clk_vga);
                #1 busy = 1'b0;
                release_cycle = cycle;
                resp_active = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic push_line();
        for (int b = 0; b < 4; b++)
            exp_q.push_back(32'(m_line * 1024 + b * 256));
        m_line = (m_line + 1) % 256;
    endtask

    task automatic pulse_prefetch();
        @(posedge clk_vga); #1 prefetch_line = 1'b1;
        @(posedge clk_vga); #1 prefetch_line = 1'b0;
    endtask

    task automatic pixel_edge(input logic [1:0] v);
        @(posedge clk_vga); #1 pixelena_edge = v;
        @(posedge clk_vga); #1 pixelena_edge = 2'b00;
        if (v == 2'b10) begin
            m_disp = (m_disp + 1) % 256;
            if (m_disp == 0) m_line = 0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || resp_active) && n < 20000) begin
            @(posedge clk_vga);
            n++;
        end
        if (n >= 20000) check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk_vga);
    endtask

    task automatic wait_kicks(input int target, input string name);
        int n = 0;
        while (kick_count < target && n < 5000) begin
            @(posedge clk_vga);
            n++;
        end
        if (n >= 5000) check({name, "_timeout"}, 32'(kick_count), 32'(target));
    endtask

    task automatic fetch_line_now();
        push_line();
        pulse_prefetch();
        wait_idle("fetch");
    endtask

    initial begin
        int k0;
        int seen;
        // reset held for 500 cycles
        repeat (500) @(posedge clk_vga);
        #1;
        check("reset_kick", {31'd0, kick}, 32'd0);
        check("reset_read_addr", read_addr, 32'd0);
        check("reset_read_num", {23'd0, read_num}, 32'd64);
        rst = 1'b1;
        repeat (20) @(posedge clk_vga);
        #1;
        check("no_kick_before_prefetch", 32'(kick_count), 32'd0);
        check("post_reset_read_addr", read_addr, 32'd0);

        // lines 0 and 1
        fetch_line_now();
        check("kicks_line0", 32'(kick_count), 32'd4);
        fetch_line_now();
        check("kicks_line1", 32'(kick_count), 32'd8);

        // pending request during a fetch, third pulse dropped
        push_line();
        k0 = kick_count;
        pulse_prefetch();
        wait_kicks(k0 + 1, "pending_first_kick");
        while (!busy) @(posedge clk_vga);
        push_line();
        pulse_prefetch();
        pulse_prefetch();
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
        exp_overrun = 1'b1;
`endif
        wait_idle("pending");
        check("kicks_after_pending", 32'(kick_count), 32'd16);
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
        check("overrun_after_drop", {31'd0, overrun}, {31'd0, exp_overrun});
`endif

        // first burst of a line held busy for 1000 cycles
        hold_long = 1'b1;
        push_line();
        k0 = kick_count;
        pulse_prefetch();
        wait_kicks(k0 + 1, "hold_first_kick");
        while (!busy) @(posedge clk_vga);
        hold_long = 1'b0;
        repeat (500) @(posedge clk_vga);
        #1;
        check("kicks_during_hold", 32'(kick_count), 32'(k0 + 1));
        wait_kicks(k0 + 2, "hold_release");
        check("kick_after_release", 32'(last_kick_cycle - release_cycle), 32'd1);
        wait_idle("hold");

        // one full frame with randomly skipped prefetches; display wrap
        // lands mid-fetch on the last line
        for (int d = 0; d < 256; d++) begin
            pixel_edge(2'b01);
            if (d == 255 || $urandom_range(0, 9) != 0) begin
                push_line();
                k0 = kick_count;
                pulse_prefetch();
                if (d == 255) begin
                    wait_kicks(k0 + 1, "wrap_kick");
                    pixel_edge(2'b10);
                    wait_idle("frame_last");
                end else begin
                    wait_idle("frame");
                    pixel_edge(2'b10);
                end
            end else begin
                repeat ($urandom_range(2, 8)) @(posedge clk_vga);
                pixel_edge(2'b10);
            end
        end
        check("model_line_after_wrap", 32'(m_line), 32'd0);
        for (int l = 0; l < 3; l++) begin
            pixel_edge(2'b01);
            fetch_line_now();
            pixel_edge(2'b10);
        end

        // reset asserted while a kick is on the bus
        push_line();
        pulse_prefetch();
        seen = 0;
        for (int n = 0; n < 2000 && seen < 2; n++) begin
            @(negedge clk_vga);
            if (kick) seen++;
        end
        check("mid_burst_second_kick_seen", 32'(seen), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("async_kick_drop", {31'd0, kick}, 32'd0);
        check("async_read_addr", read_addr, 32'd0);
        exp_q.delete();
        m_line = 0;
        m_disp = 0;
        last_kick_cycle = -1;
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
        exp_overrun = 1'b0;
        check("overrun_reset", {31'd0, overrun}, 32'd0);
`endif
        for (int n = 0; n < 2000 && resp_active; n++) @(posedge clk_vga);
        repeat (5) @(posedge clk_vga);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk_vga);
        k0 = kick_count;
        fetch_line_now();
        check("kicks_after_reset", 32'(kick_count - k0), 32'd4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef HDMI_AXI_LINE_FETCH_OVERRUN_EN
        check("overrun_final", {31'd0, overrun}, {31'd0, exp_overrun});
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
